// File: rtl/pipe_fetch_ctrl_pkg.sv
// pipe_fetch_ctrl_pkg: shared next-PC select codes, fetch FSM states and default reset PC
package pipe_fetch_ctrl_pkg;

    localparam logic [1:0] PCS_PC4 = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JR  = 2'b10;
    localparam logic [1:0] PCS_J   = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

endpackage

// File: rtl/pipe_fetch_ctrl_sat_counter.sv
// sat_counter: enable counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb cnt_d = (en && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// pipe_fetch_ctrl: IF-stage sequencer owning the PC, next-PC select, ROM address and fetch stats
module pipe_fetch_ctrl
    import pipe_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int          CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             jr_taken,
    input  logic             j_taken,
    input  logic [31:0]      bpc,
    input  logic [31:0]      da,
    input  logic [31:0]      jpc,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    output logic [31:0]      npc,
    output logic [1:0]       pcsource,
    output logic [7:0]       rom_addr,
    output logic             if_valid,
    output logic             redirect,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    state_t      state_d, state_q;
    logic [31:0] pc_d, pc_q;
    logic        run_go;

    always_comb begin
        run_go   = (state_q == RUN) && !stall;
        pc4      = pc_q + 32'd4;
        pcsource = !run_go  ? PCS_PC4 :
                   jr_taken ? PCS_JR  :
                   j_taken  ? PCS_J   :
                   br_taken ? PCS_BR  : PCS_PC4;
        redirect = run_go && (jr_taken || j_taken || br_taken);
        npc      = (pcsource == PCS_BR) ? bpc :
                   (pcsource == PCS_JR) ? da  :
                   (pcsource == PCS_J)  ? jpc : pc4;
        pc_d     = run_go ? npc : pc_q;
        state_d  = (state_q == BOOT) ? RUN : stall ? HOLD : RUN;
        // ROM latches on the same edge as pc, so feed it the value pc is about to take
        rom_addr = run_go ? npc[9:2] : pc_q[9:2];
        if_valid = (state_q != BOOT) && !(redirect && !DELAY_SLOT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc = pc_q;

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clock (clock),
        .reset (reset),
        .en    (if_valid && !stall),
        .cnt   (fetch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .en    (!if_valid),
        .cnt   (bubble_cnt)
    );

endmodule
